mul_wb_queue: RTL
=================

// Module: mul_wb_queue
// PURPOSE
//  Receive side of the multiplier completion interface. Captures every result the fixed-latency
//  multiplier pipeline emits (no back-pressure exists on that pipe) into a small FIFO. Drains
//  results to the dedicated HILO PRF write port or the shared GPR PRF write port, and signals
//  ROB completion. Gives the issue stage a credit signal so the FIFO can never overflow.
// PARAMETERS
//  DEPTH     4  FIFO entries; power of two, >=2
//  LG_DEPTH  2  log2(DEPTH)
//  (ROB/PRF widths come from `LG_ROB_ENTRIES, `LG_PRF_ENTRIES, `LG_HILO_PRF_ENTRIES in uop.vh)
// PORTS
//  clk             in   1     clock, all state on posedge
//  reset           in   1     asynchronous, active-high
//  mul_go          in   1     issue stage launches one multiply this cycle
//  mul_ready       out  1     credit available; issue may assert mul_go
//  flush           in   1     pipeline flush (synchronous)
//  mul_complete    in   1     multiplier result valid
//  mul_y           in   64    multiplier result
//  mul_rob_ptr     in   LG_ROB   ROB index of result
//  mul_gpr_val     in   1     result targets GPR PRF
//  mul_gpr_ptr     in   LG_PRF   GPR PRF index
//  mul_hilo_val    in   1     result targets HILO PRF
//  mul_hilo_ptr    in   LG_HILO  HILO PRF index
//  gpr_wr_req      out  1     request shared GPR write port
//  gpr_wr_grant    in   1     port granted this cycle (arbiter may combinationally use req)
//  gpr_wr_ptr      out  LG_PRF   GPR write index
//  gpr_wr_data     out  32    GPR write data = y[31:0]
//  hilo_wr_en      out  1     HILO write strobe (dedicated port, never stalls)
//  hilo_wr_ptr     out  LG_HILO  HILO write index
//  hilo_wr_data    out  64    HILO write data = y
//  rob_cmpl_val    out  1     ROB completion strobe
//  rob_cmpl_ptr    out  LG_ROB   ROB index completed
// BEHAVIOUR
//  - State: FIFO (rd/wr ptr LG_DEPTH+1 bits, wrap on MSB), inflight and drop_cnt counters (LG_DEPTH+1).
//  - Reset: FIFO empty, inflight=0, drop_cnt=0. All strobes/req 0; data/ptr outputs 0. mul_ready=1.
//  - Credits: mul_ready = (count + inflight + drop_cnt) < DEPTH, from registered state only.
//    inflight +1 on mul_go (ignored while flush), -1 on mul_complete; both same cycle -> unchanged.
//  - Push: mul_complete && drop_cnt==0 -> write {y,rob,gpr_val/ptr,hilo_val/ptr} at tail.
//    Push while full without pop is a protocol violation: entry dropped, sim assertion fires.
//  - Head drain (combinational from head entry):
//    hilo_val  -> hilo_wr_en=1, rob_cmpl_val=1, pop unconditionally.
//    gpr_val   -> gpr_wr_req=1; pop and rob_cmpl_val=1 only in a gpr_wr_grant cycle.
//    neither   -> rob_cmpl_val=1, pop unconditionally.
//    gpr_val and hilo_val are never both set (one-hot destination from issue).
//    At most one pop per cycle; strobes 0 when empty.
//  - Latency: completion at cycle t into an empty FIFO -> write/complete at t+1 (if granted).
//  - Simultaneous push+pop: count unchanged; works when full (pop frees slot for push).
//  - Order: strictly in completion order; a blocked GPR head stalls HILO entries behind it.
//  - flush: FIFO emptied next cycle; no pop or strobes in the flush cycle.
//    drop_cnt <= drop_cnt + inflight - mul_complete; inflight <= 0.
//    While drop_cnt>0, each mul_complete decrements drop_cnt and is discarded.
//  - reset mid-operation: all state cleared immediately; in-pipe results are the multiplier's
//    reset concern.
// CONFIGURATION
//  MUL_WB_BYPASS_EN defined: when FIFO empty and mul_complete, the result is presented on the write
//   ports the same cycle (0-cycle latency). It completes without enqueue if HILO/none, or if GPR
//   and granted; otherwise it is enqueued.
//  Undefined: every result goes through the FIFO (1-cycle minimum latency, no comb path in->out).
// TESTING
//  1 HILO result y=64'h1_0000_0002, hilo_ptr=3, rob=5 at t -> hilo_wr_en@t+1, ptr 3, data match,
//    rob_cmpl_ptr=5.
//  2 GPR result y=..._DEADBEEF, grant low 3 cycles -> req held 3 cycles, write 32'hDEADBEEF on
//    grant cycle, single rob_cmpl.
//  3 Issue 4 mul_go back-to-back, grant low -> mul_ready=0 after 4th; 4 results queue; grant high
//    -> 4 in-order writes, then mul_ready=1.
//  4 Full FIFO, push+pop same cycle -> count stays 4, no loss, no assertion.
//  5 2 in flight, flush -> next 2 mul_complete dropped (no strobes), drop_cnt=0, mul_ready=1.
//  6 With MUL_WB_BYPASS_EN, empty FIFO, GPR result + grant at t -> write and rob_cmpl at t;
//    without it -> at t+1.

Source files
------------

// File: rtl/mul_wb_queue.sv
// mul_wb_queue
//   Receive side of the multiplier completion interface. The multiplier
//   pipeline has a fixed latency and cannot be stalled, so every result it
//   emits is captured here in a small FIFO. Results then drain in completion
//   order to one of two places:
//     - the dedicated HILO PRF write port, which never stalls
//     - the shared GPR PRF write port, which must be granted
//   Each drained result also raises a ROB completion. The issue stage only
//   launches a multiply while mul_ready is high. This credit check counts
//   queued entries, results still in flight, and results that are doomed to
//   be discarded after a flush, so the FIFO can never overflow.
//
// Configuration macro
//   MUL_WB_BYPASS_EN : when defined, a result that arrives while the FIFO is
//                      empty is presented on the write ports in the same cycle.
//                      When undefined, every result passes through the FIFO,
//                      and there is no combinational path from inputs to the
//                      write ports.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   mul_go / mul_ready    issue launches a multiply / credit available
//   flush                 synchronous pipeline flush
//   mul_complete, mul_*   result and destination info from the multiplier
//   gpr_wr_*              shared GPR PRF write port (req/grant handshake)
//   hilo_wr_*             dedicated HILO PRF write port
//   rob_cmpl_*            ROB completion strobe and index
module mul_wb_queue #(
  parameter int DEPTH    = 4,
  parameter int LG_DEPTH = 2,
  parameter int LG_ROB   = 6,
  parameter int LG_PRF   = 6,
  parameter int LG_HILO  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mul_go,
  output logic               mul_ready,
  input  logic               flush,
  input  logic               mul_complete,
  input  logic [63:0]        mul_y,
  input  logic [LG_ROB-1:0]  mul_rob_ptr,
  input  logic               mul_gpr_val,
  input  logic [LG_PRF-1:0]  mul_gpr_ptr,
  input  logic               mul_hilo_val,
  input  logic [LG_HILO-1:0] mul_hilo_ptr,
  output logic               gpr_wr_req,
  input  logic               gpr_wr_grant,
  output logic [LG_PRF-1:0]  gpr_wr_ptr,
  output logic [31:0]        gpr_wr_data,
  output logic               hilo_wr_en,
  output logic [LG_HILO-1:0] hilo_wr_ptr,
  output logic [63:0]        hilo_wr_data,
  output logic               rob_cmpl_val,
  output logic [LG_ROB-1:0]  rob_cmpl_ptr
);

  localparam int CW = LG_DEPTH + 1;

  typedef struct packed {
    logic [63:0]        y;
    logic [LG_ROB-1:0]  rob;
    logic               gv;
    logic [LG_PRF-1:0]  gp;
    logic               hv;
    logic [LG_HILO-1:0] hp;
  } entry_t;

  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] inflight_q, inflight_d, drop_cnt_q, drop_cnt_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic          empty, full, dropping, accept, done, pop, push_en, bypass_done;
  logic [CW-1:0] count;
  logic [CW+1:0] credit_sum;
  entry_t        in_entry, head, sel;
  logic          sel_valid;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  // Full when the index bits match but the wrap bits differ.
  assign full     = (wr_ptr_q[LG_DEPTH] != rd_ptr_q[LG_DEPTH]) &&
                    (wr_ptr_q[LG_DEPTH-1:0] == rd_ptr_q[LG_DEPTH-1:0]);
  assign dropping = (drop_cnt_q != '0);
  // A result is kept only outside a flush and once all pre-flush results have drained.
  assign accept   = mul_complete && !dropping && !flush;
  assign head     = mem_q[rd_ptr_q[LG_DEPTH-1:0]];

  // Credits come only from registered state, so issue sees no comb path from the write ports.
  assign credit_sum = {2'b00, count} + {2'b00, inflight_q} + {2'b00, drop_cnt_q};
  assign mul_ready  = (credit_sum < (CW+2)'(DEPTH));

  always_comb begin
    in_entry    = '0;
    in_entry.y  = mul_y;
    in_entry.rob = mul_rob_ptr;
    in_entry.gv = mul_gpr_val;
    in_entry.gp = mul_gpr_ptr;
    in_entry.hv = mul_hilo_val;
    in_entry.hp = mul_hilo_ptr;
  end

  // Pick the entry presented on the write ports and decide whether it retires this cycle.
  always_comb begin
    sel          = head;
    sel_valid    = !empty && !flush;
`ifdef MUL_WB_BYPASS_EN
    if (empty && accept) begin
      sel       = in_entry;
      sel_valid = 1'b1;
    end
`endif
    done         = 1'b0;
    gpr_wr_req   = 1'b0;
    hilo_wr_en   = 1'b0;
    rob_cmpl_val = 1'b0;
    gpr_wr_ptr   = '0;
    gpr_wr_data  = '0;
    hilo_wr_ptr  = '0;
    hilo_wr_data = '0;
    rob_cmpl_ptr = '0;
    if (sel_valid) begin
      gpr_wr_ptr   = sel.gp;
      gpr_wr_data  = sel.y[31:0];
      hilo_wr_ptr  = sel.hp;
      hilo_wr_data = sel.y;
      rob_cmpl_ptr = sel.rob;
      if (sel.hv) begin
        hilo_wr_en   = 1'b1;
        rob_cmpl_val = 1'b1;
        done         = 1'b1;
      end else if (sel.gv) begin
        gpr_wr_req = 1'b1;
        if (gpr_wr_grant) begin
          rob_cmpl_val = 1'b1;
          done         = 1'b1;
        end
      end else begin
        rob_cmpl_val = 1'b1;
        done         = 1'b1;
      end
    end
  end

  assign pop = done && !empty;
`ifdef MUL_WB_BYPASS_EN
  assign bypass_done = done && empty;
`else
  assign bypass_done = 1'b0;
`endif
  // When the FIFO is full, a push is legal only if a pop frees a slot in the same cycle.
  assign push_en = accept && !bypass_done && (!full || pop);

  // Next-state for pointers, storage and the credit counters.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (flush) begin
      rd_ptr_d   = wr_ptr_q;
      inflight_d = '0;
      // Every result still in the pipe must be discarded when it arrives,
      // except one that completes in this same cycle.
      drop_cnt_d = drop_cnt_q + inflight_q - CW'(mul_complete);
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q[LG_DEPTH-1:0]] = in_entry;
        wr_ptr_d = wr_ptr_q + CW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + CW'(1);
      // Completions retire pre-flush results first, so they only reduce inflight once drop_cnt is zero.
      inflight_d = inflight_q + CW'(mul_go) - CW'(mul_complete && !dropping);
      if (mul_complete && dropping) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // A result arriving at a full FIFO with no pop would be lost.
  overflow_chk: assert property (@(posedge clk) disable iff (reset)
                                 !(accept && full && !pop));

endmodule
